// File: rtl/bus_master_if.sv
// bus_master_if: groups the client command/response port and the memory bus
// port of bus_master.
//   cmd_*      client command (valid/ready)
//   rsp_*      response back to the client (valid/ready)
//   bus_addr/bus_wdata/bus_ctrl   toward the device; ctrl = {0, BE, WE, REQ}
//   bus_rdata/bus_status          from the device;  status[0]=ACK, [1]=ERR
// Modports: master = bus_master side, slave = client/device side.
interface bus_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [15:0] bus_ctrl;
   logic [31:0] bus_rdata;
   logic [15:0] bus_status;

   modport master (
      input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_be, rsp_ready,
             bus_rdata, bus_status,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             bus_addr, bus_wdata, bus_ctrl
   );

   modport slave (
      output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_be, rsp_ready,
             bus_rdata, bus_status,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             bus_addr, bus_wdata, bus_ctrl
   );
endinterface

// File: rtl/bus_master.sv
// bus_master: initiator end of the 32-bit memory bus. Takes one single-word
// read/write command at a time, runs it on the bus until the device ACKs,
// and returns rdata/err on the response port.
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   bus_master_if.master (command, response and device lines)
// Parameter TIMEOUT (1..65535): REQ cycles without ACK before the watchdog
// ends the transaction with an error. Only used when the macro
// BUS_MASTER_TIMEOUT_EN is defined; otherwise REQ waits forever for ACK.
module bus_master #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rst,
   bus_master_if.master bus
);

   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("bus_master: TIMEOUT must be in 1..65535");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [3:0]  be_q, be_d;
   logic        we_q, we_d;
   logic        err_q, err_d;

   logic        ack, dev_err, req;

   assign ack     = bus.bus_status[0];
   assign dev_err = bus.bus_status[1];

   // Upper status bits carry nothing for this block.
   logic unused_status;
   assign unused_status = ^bus.bus_status[15:2];

`ifdef BUS_MASTER_TIMEOUT_EN
   // The count that would reach TIMEOUT on this cycle is TIMEOUT-1 now.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
   logic [15:0] cnt_q, cnt_d;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      be_d    = be_q;
      we_d    = we_q;
      err_d   = err_q;
`ifdef BUS_MASTER_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               addr_d  = bus.cmd_addr;
               wdata_d = bus.cmd_wdata;
               we_d    = bus.cmd_we;
               be_d    = bus.cmd_be;
               rdata_d = '0;
               if (bus.cmd_addr[1:0] != 2'b00) begin
                  // Misaligned: answer with an error, no bus cycle.
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = REQ;
`ifdef BUS_MASTER_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end
         end
         REQ: begin
            if (ack) begin
               err_d   = dev_err;
               rdata_d = (!we_q && !dev_err) ? bus.bus_rdata : 32'd0;
               state_d = RESP;
            end
`ifdef BUS_MASTER_TIMEOUT_EN
            // ACK is checked first, so it wins over an expiring watchdog.
            else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         RESP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         be_q    <= be_d;
         we_q    <= we_d;
         err_q   <= err_d;
`ifdef BUS_MASTER_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Gated by rst so REQ and cmd_ready drop the moment reset asserts.
   assign req           = rst && (state_q == REQ);
   assign bus.cmd_ready = rst && (state_q == IDLE);
   assign bus.rsp_valid = rst && (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_wdata = wdata_q;
   // WE/BE only visible while REQ is high; the whole control word is 0 otherwise.
   assign bus.bus_ctrl  = {10'd0, req ? be_q : 4'd0, req & we_q, req};

endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: directed + randomized checks of bus_master against a
// transaction-level model of the expected response and bus activity.
module tb_bus_master;
   localparam int unsigned TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   bus_master_if bif ();

   bus_master #(.TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          req_cycles;
   } exp_t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected outcome of one command from the bus rules alone.
   function automatic exp_t model(input logic we, input logic [31:0] addr,
                                  input logic [31:0] dev_rdata, input logic dev_err,
                                  input int waits);
      exp_t e;
      if (addr % 4 != 0) begin
         e.err = 1'b1; e.rdata = 32'd0; e.req_cycles = 0;
         return e;
      end
`ifdef BUS_MASTER_TIMEOUT_EN
      if (waits >= int'(TO)) begin
         e.err = 1'b1; e.rdata = 32'd0; e.req_cycles = int'(TO);
         return e;
      end
`endif
      e.req_cycles = waits + 1;
      e.err        = dev_err;
      e.rdata      = (we || dev_err) ? 32'd0 : dev_rdata;
      return e;
   endfunction

   // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 after
   // the response handshake edge (DUT back in IDLE).
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] dev_rdata,
                          input logic dev_err, input int waits, input int rsp_delay);
      exp_t        e;
      logic [31:0] exp_ctrl;
      logic [31:0] r;
      e        = model(we, addr, dev_rdata, dev_err, waits);
      exp_ctrl = {16'd0, 10'd0, be, we, 1'b1};
      bif.cmd_valid = 1'b1;
      bif.cmd_we    = we;
      bif.cmd_addr  = addr;
      bif.cmd_wdata = wdata;
      bif.cmd_be    = be;
      @(negedge clk);
      chk("idle_cmd_ready", bif.cmd_ready, 1);
      chk("idle_rsp_valid", bif.rsp_valid, 0);
      chk("idle_bus_ctrl", bif.bus_ctrl, 0);
      @(posedge clk); #1;
      // Scramble the command lines: the DUT must hold its registered copy.
      r = $urandom(); bif.cmd_valid = 1'b0; bif.cmd_we = r[0]; bif.cmd_be = r[7:4];
      bif.cmd_addr = $urandom(); bif.cmd_wdata = $urandom();
      for (int i = 0; i < e.req_cycles; i++) begin
         r = $urandom();
         if (i == waits) begin
            bif.bus_status = {r[15:2], dev_err, 1'b1};
            bif.bus_rdata  = dev_rdata;
         end else begin
            bif.bus_status = {r[15:1], 1'b0};
            bif.bus_rdata  = $urandom();
         end
         @(negedge clk);
         chk("req_bus_ctrl", bif.bus_ctrl, exp_ctrl);
         chk("req_bus_addr", bif.bus_addr, addr);
         chk("req_bus_wdata", bif.bus_wdata, wdata);
         chk("req_cmd_ready", bif.cmd_ready, 0);
         chk("req_rsp_valid", bif.rsp_valid, 0);
         @(posedge clk); #1;
      end
      for (int d = 0; d <= rsp_delay; d++) begin
         // Device lines are junk here (ACK may be high): must be ignored.
         bif.bus_status = 16'($urandom());
         bif.bus_rdata  = $urandom();
         bif.rsp_ready  = (d == rsp_delay);
         @(negedge clk);
         chk("rsp_valid", bif.rsp_valid, 1);
         chk("rsp_rdata", bif.rsp_rdata, e.rdata);
         chk("rsp_err", bif.rsp_err, e.err);
         chk("rsp_bus_ctrl", bif.bus_ctrl, 0);
         chk("rsp_cmd_ready", bif.cmd_ready, 0);
         @(posedge clk); #1;
      end
      bif.rsp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      bif.cmd_valid  = 1'b0;
      bif.cmd_we     = 1'b0;
      bif.cmd_addr   = '0;
      bif.cmd_wdata  = '0;
      bif.cmd_be     = '0;
      bif.rsp_ready  = 1'b0;
      bif.bus_rdata  = '0;
      bif.bus_status = '0;

      // Reset state: every output 0, cmd_ready included.
      #12;
      chk("rst_cmd_ready", bif.cmd_ready, 0);
      chk("rst_rsp_valid", bif.rsp_valid, 0);
      chk("rst_rsp_err", bif.rsp_err, 0);
      chk("rst_rsp_rdata", bif.rsp_rdata, 0);
      chk("rst_bus_addr", bif.bus_addr, 0);
      chk("rst_bus_wdata", bif.bus_wdata, 0);
      chk("rst_bus_ctrl", bif.bus_ctrl, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Read, zero-wait ACK.
      run_txn(1'b0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 0, 0);
      // Write with 3 wait cycles.
      run_txn(1'b1, 32'h20, 32'h12345678, 4'h3, 32'hA5A5A5A5, 1'b0, 3, 0);
      // Device error on a read.
      run_txn(1'b0, 32'h40, 32'h0, 4'hF, 32'hCAFEF00D, 1'b1, 1, 0);
      // Misaligned read: no bus cycle.
      run_txn(1'b0, 32'h103, 32'h0, 4'hF, 32'h11111111, 1'b0, 0, 0);
      // Write with all byte enables off still goes on the bus.
      run_txn(1'b1, 32'h44, 32'h87654321, 4'h0, 32'h0, 1'b0, 0, 0);
      // Response backpressure for 5 cycles.
      run_txn(1'b0, 32'h80, 32'h0, 4'hF, 32'h0BADCAFE, 1'b0, 2, 5);

      // Reset in the middle of REQ.
      bif.cmd_valid = 1'b1; bif.cmd_we = 1'b1; bif.cmd_addr = 32'h200;
      bif.cmd_wdata = 32'h55AA55AA; bif.cmd_be = 4'hC;
      @(posedge clk); #1;
      bif.cmd_valid  = 1'b0;
      bif.bus_status = 16'h0000;
      @(negedge clk);
      chk("mid_req_ctrl", bif.bus_ctrl, 32'h33);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_ctrl", bif.bus_ctrl, 0);
      chk("mid_rst_cmd_ready", bif.cmd_ready, 0);
      chk("mid_rst_bus_addr", bif.bus_addr, 0);
      bif.bus_status = 16'h0001;
      bif.bus_rdata  = 32'hFFFFFFFF;
      @(posedge clk); #2;
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_cmd_ready", bif.cmd_ready, 1);
      chk("post_rst_ctrl", bif.bus_ctrl, 0);
      chk("post_rst_rsp_valid", bif.rsp_valid, 0);
      @(posedge clk); #1;
      bif.bus_status = 16'h0000;
      @(negedge clk);
      chk("late_ack_rsp_valid", bif.rsp_valid, 0);
      chk("late_ack_cmd_ready", bif.cmd_ready, 1);
      @(posedge clk); #1;

`ifdef BUS_MASTER_TIMEOUT_EN
      // Device never ACKs: watchdog after TO REQ cycles.
      run_txn(1'b0, 32'h300, 32'h0, 4'hF, 32'h12121212, 1'b0, 1000, 0);
      // ACK on the last watchdog cycle wins.
      run_txn(1'b0, 32'h304, 32'h0, 4'hF, 32'h34343434, 1'b0, int'(TO) - 1, 0);
`endif

      // Randomized traffic.
      for (int t = 0; t < 40; t++) begin
         logic [31:0] a;
         r = $urandom();
         a = {$urandom_range(0, 32'h0FFF), 2'b00};
         if (r[1:0] == 2'b00) a[1:0] = r[3:2] | 2'b01;
         run_txn(r[4], a, $urandom(), r[11:8], $urandom(), r[12] & r[13],
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/bus_master.md
# bus_master

Initiator end of the 32-bit memory bus. Accepts single-word read and write commands from a client such as a core load/store unit or a DMA. Drives the bus address, data and control lines toward a memory device, waits for its acknowledge, and returns the response through a valid/ready port. Only one transaction is outstanding at a time. An optional watchdog ends a transaction that the device never acknowledges.

## Interface
Parameters:
- TIMEOUT, 255: cycles in REQ without ACK before the watchdog fires (1..65535); used only with BUS_MASTER_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  client command valid
- cmd_ready  out  1  block can accept a command
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- cmd_be  in  4  byte enables
- rsp_valid  out  1  response valid
- rsp_ready  in  1  client accepts response
- rsp_rdata  out  32  read data (0 for writes and errors)
- rsp_err  out  1  transaction failed
- bus_addr  out  32  address to device
- bus_wdata  out  32  write data to device
- bus_ctrl  out  16  control to device: [0] REQ, [1] WE, [5:2] BE, [15:6] driven 0
- bus_rdata  in  32  read data from device
- bus_status  in  16  status from device: [0] ACK, [1] ERR, rest ignored

## Operation
The state machine has three states: IDLE, REQ and RESP.

- IDLE
  - cmd_ready = 1.
  - On cmd_valid, register cmd_addr, cmd_wdata, cmd_we and cmd_be.
  - If cmd_addr[1:0] != 0 (misaligned): go to RESP with rsp_err = 1 and rsp_rdata = 0. No bus cycle is issued.
  - Otherwise go to REQ.
- REQ
  - bus_ctrl[0] = 1, with WE and BE taken from the registered command.
  - bus_addr and bus_wdata show the registered values and stay stable for the whole state.
  - If bus_status[0] (ACK) is sampled high:
    - Capture rsp_err = bus_status[1].
    - Capture rsp_rdata = bus_rdata, but only for a read with ERR = 0; otherwise 0.
    - Go to RESP.
- RESP
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable.
  - REQ = 0.
  - On rsp_ready, go to IDLE.
- cmd_ready is 1 only in IDLE. A command cannot be accepted in the cycle a response is consumed.
- bus_addr and bus_wdata keep their last registered value outside REQ. bus_ctrl is 0 outside REQ.
- ACK, ERR and bus_rdata are ignored outside REQ.
- With cmd_we = 1 and cmd_be = 0, a normal bus write is issued with BE = 0.

## Timing
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - cmd_ready = 1 once rst is high; during reset all outputs are 0, including cmd_ready.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, bus_addr = 0, bus_wdata = 0, bus_ctrl = 0.
  - Reset during REQ drops REQ immediately (combinationally). A late ACK is ignored.
- Latency:
  - Command accepted at edge N; REQ is high in cycle N+1.
  - ACK sampled at edge N+1+k (k ≥ 0 wait cycles) gives rsp_valid high from cycle N+2+k.
  - Best case: 2 cycles from acceptance to rsp_valid.
  - A misaligned command gives rsp_valid in cycle N+1.
- REQ falls in the cycle after ACK is sampled. The device must treat ACK as a one-cycle pulse per REQ.
- rsp_ready held high gives a back-to-back throughput of one transaction per 3 cycles (zero-wait device).

## Configuration
- BUS_MASTER_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to REQ and increments every REQ cycle without ACK.
  - When the count reaches TIMEOUT: drop REQ, go to RESP with rsp_err = 1 and rsp_rdata = 0.
  - If ACK arrives in the same cycle the count reaches TIMEOUT, ACK wins.
- Not defined: no counter; REQ is held until ACK arrives, indefinitely.

## Test plan
- Reset and read: release rst, issue read addr 0x100, device ACKs at once with rdata 0xDEADBEEF. Required:
  - REQ high exactly 1 cycle, WE = 0, BE = 0xF.
  - rsp_valid 2 cycles after acceptance, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Write with wait states: write addr 0x20, data 0x12345678, be 0x3; ACK after 3 wait cycles. Required:
  - bus_ctrl = 0x000F for 4 cycles (REQ = 1, WE = 1, BE = 0x3), with bus lines stable throughout.
  - rsp_rdata = 0, rsp_err = 0.
- Device error: read with ACK = 1 and ERR = 1 -> rsp_err = 1, rsp_rdata = 0.
- Misaligned: read addr 0x103 -> REQ never asserts; rsp_valid next cycle with rsp_err = 1.
- Backpressure and mid-operation reset:
  - Hold rsp_ready low 5 cycles: rsp_* stays stable and cmd_ready stays 0.
  - Then assert rst low while in REQ: bus_ctrl = 0 immediately and state returns to IDLE.
- Timeout (BUS_MASTER_TIMEOUT_EN, TIMEOUT = 4), device never ACKs:
  - REQ high for exactly 4 cycles, then rsp_err = 1.
  - Repeat with ACK in the 4th cycle: ACK wins, rsp_err = 0.
